alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Decode/issue stage that drives the ALU's operation and operand interface.
- Decodes RV32I OP, OP-IMM and LUI instructions into op_val, signed_unsigned_n and two 32-bit operands. It also outputs register-file read addresses.
- Resolves read-after-write hazards by forwarding the ALU's combinational result and registered result, then registers everything into the ID/EX pipeline register the ALU consumes.

Parameters:
- XLEN, 32, datapath width; only 32 supported.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- halt  in  1  CPU halt; freezes all registers, same as ALU halt
- flush  in  1  discard instruction being decoded; next issue is a bubble
- instr_valid  in  1  instr holds a valid instruction
- instr  in  32  instruction word
- instr_ready  out  1  comb; instruction accepted on this edge
- rs1_addr  out  5  comb, instr[19:15]
- rs2_addr  out  5  comb, instr[24:20]
- rs1_data  in  32  register file read data (comb, same cycle)
- rs2_data  in  32  register file read data
- alu_result_comb  in  32  ALU unregistered result of instruction currently in EX
- alu_result_wb  in  32  ALU registered result (instruction in WB)
- op_val  out  4  registered ALU op
- signed_unsigned_n  out  1  registered; 1 for SLT/SLTI/SRA/SRAI, else 0
- operand_a  out  32  registered
- operand_b  out  32  registered
- rd_addr  out  5  registered destination
- rd_we  out  1  registered write enable
- issue_valid  out  1  registered; output register holds a real instruction
- illegal_instr  out  1  registered one-cycle pulse

Behaviour:
- Reset (async, rst=1): all registered outputs are 0, op_val=4'b0000 (NOP), and internal wb_rd/wb_we are 0.
- Latency: an accepted instruction appears on the outputs one clk later.
- op_val encoding:
  - 0001 ADD/ADDI/LUI
  - 0010 SUB
  - 0011 SLT/SLTI
  - 1011 SLTU/SLTIU
  - 0100 AND
  - 0101 OR
  - 0110 XOR
  - 0111 SLL
  - 1000 SRL
  - 1001 SRA
  - 0000 NOP/bubble
- Operand selection:
  - OP: a=rs1 value, b=rs2 value. SUB/SRA are selected by funct7=0100000.
  - OP-IMM: b=sign-extended imm[11:0]. Shifts use b={27'b0,shamt}, and SRAI is selected by imm[10].
  - LUI: a=0, b={instr[31:12],12'b0}, rd_we=1.
  - Register shifts: b masked to {27'b0, rs2 value[4:0]}.
  - signed_unsigned_n: per the Ports definition (1 for SLT/SLTI/SRA/SRAI, 0 otherwise).
- Illegal: any other opcode, or bad funct7 on OP (not 0000000/0100000, or 0100000 with funct3 other than ADD/SRL) produces a bubble with illegal_instr=1 for one cycle.
- Forwarding priority for each of rs1 and rs2, applied only when the address is nonzero:
  1. EX match: issue_valid & rd_we & rd_addr==rsX selects alu_result_comb.
  2. WB match: wb_we & wb_rd==rsX selects alu_result_wb.
  3. Otherwise the register file data is used.
- x0 always reads 0.
- Tracking register: on each non-halted edge, wb_rd<=rd_addr and wb_we<=rd_we&issue_valid.
- Handshake: instr_ready = !halt & !stall. Without instr_ready, the instruction is held by upstream.
- Bubbles: instr_valid=0 or flush=1 on a non-halted edge issues a bubble (issue_valid=0, rd_we=0, op_val=0, operands=0).
- Flush with instr_valid=1: instr_ready=1 and the instruction is dropped.
- Halt: all registers, including wb tracking, hold their values.
- Simultaneous events:
  - halt+flush: halt wins and the flush is lost; upstream must re-assert.
  - rst mid-operation: immediate clear, no partial issue.
- The rd_addr=0 write is issued as decoded (rd_we=1), but the x0 guard prevents it from ever forwarding.

Optional Feature:
- Macro: ALU_ISSUE_WB_FWD_EN.
- Defined: the WB forwarding path is active as above, and stall is always 0.
- Undefined: alu_result_wb is ignored.
  - stall=1 whenever a WB match exists and no EX match exists for that operand.
  - During stall: instr_ready=0 and a bubble is issued.
  - The next cycle re-decodes and reads the now-written register file.

Test Plan:
- Reset: assert rst mid-stream with outputs nonzero -> all outputs 0 asynchronously, before the next clk edge; op_val=0000 after release until the first valid instr.
- Decode: ADDI x1,x0,-5 with rs1_data=0 -> next cycle op_val=0001, a=0, b=32'hFFFF_FFFB, rd_addr=1, rd_we=1, issue_valid=1.
- EX forward: ADDI x1,x0,7 then ADD x2,x1,x1 back-to-back with alu_result_comb=7, rs1_data=0 -> ADD issues with a=b=7.
- WB forward: producer x3, independent instr, then SUB x4,x3,x0 with alu_result_wb=32'h10.
  - Macro defined: a=32'h10, no stall.
  - Macro undefined: one bubble, instr_ready=0 for 1 cycle, then a=rs1_data.
- Halt/flush: halt=1 for 3 cycles -> outputs frozen and instr_ready=0. flush=1 with a valid SLT -> instr_ready=1, next issue_valid=0, op_val=0000.
- Illegal: instr=32'h0000_0073 (ECALL) -> illegal_instr=1 for exactly 1 cycle, rd_we=0, issue_valid=0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes RV32I OP / OP-IMM / LUI into the ALU's op/operand interface and
// registers it into the ID/EX pipeline register (one clk from accept to outputs).
// Backpressure: instr_ready = !halt & !stall; halt freezes every register, flush turns the
// instruction being decoded into a bubble, illegal encodings issue a bubble plus a 1-cycle flag.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   halt, flush                 freeze all state / drop the instruction being decoded
//   instr_valid, instr          instruction from fetch; instr_ready (comb) accepts it
//   rs1_addr, rs2_addr          comb register-file read addresses (instr[19:15], instr[24:20])
//   rs1_data, rs2_data          register-file read data, same cycle
//   alu_result_comb             ALU result of the instruction currently in EX
//   alu_result_wb               ALU registered result (instruction in WB)
//   op_val, signed_unsigned_n,
//   operand_a, operand_b,
//   rd_addr, rd_we, issue_valid,
//   illegal_instr               registered ID/EX outputs
//
// Build option: ALU_ISSUE_WB_FWD_EN
//   defined   - WB hazards are resolved by forwarding alu_result_wb, never stalls.
//   undefined - alu_result_wb is ignored; a WB-only hazard stalls one cycle (bubble issued)
//               and the instruction is re-decoded once the register file holds the value.

module alu_issue_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  halt,
    input  logic                  flush,
    input  logic                  instr_valid,
    input  logic [31:0]           instr,
    output logic                  instr_ready,
    output logic [REG_ADDR_W-1:0] rs1_addr,
    output logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    input  logic [XLEN-1:0]       alu_result_comb,
    input  logic [XLEN-1:0]       alu_result_wb,
    output logic [3:0]            op_val,
    output logic                  signed_unsigned_n,
    output logic [XLEN-1:0]       operand_a,
    output logic [XLEN-1:0]       operand_b,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic                  rd_we,
    output logic                  issue_valid,
    output logic                  illegal_instr
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [3:0] OPV_NOP  = 4'b0000;
    localparam logic [3:0] OPV_ADD  = 4'b0001;
    localparam logic [3:0] OPV_SUB  = 4'b0010;
    localparam logic [3:0] OPV_SLT  = 4'b0011;
    localparam logic [3:0] OPV_SLTU = 4'b1011;
    localparam logic [3:0] OPV_AND  = 4'b0100;
    localparam logic [3:0] OPV_OR   = 4'b0101;
    localparam logic [3:0] OPV_XOR  = 4'b0110;
    localparam logic [3:0] OPV_SLL  = 4'b0111;
    localparam logic [3:0] OPV_SRL  = 4'b1000;
    localparam logic [3:0] OPV_SRA  = 4'b1001;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];

    // ID/EX register and WB tracking state
    logic [3:0]            op_val_q,  op_val_d;
    logic                  sun_q,     sun_d;
    logic [XLEN-1:0]       op_a_q,    op_a_d;
    logic [XLEN-1:0]       op_b_q,    op_b_d;
    logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic                  rd_we_q,   rd_we_d;
    logic                  issue_valid_q, issue_valid_d;
    logic                  illegal_q, illegal_d;
    logic [REG_ADDR_W-1:0] wb_rd_q,   wb_rd_d;
    logic                  wb_we_q,   wb_we_d;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    logic [3:0] dec_op;
    logic       dec_sun;
    logic       dec_legal;
    logic       use_rs1;
    logic       use_rs2;
    logic       is_imm;
    logic       is_lui;
    logic       is_shift;

    always_comb begin
        dec_op    = OPV_NOP;
        dec_sun   = 1'b0;
        dec_legal = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        is_imm    = 1'b0;
        is_lui    = 1'b0;
        is_shift  = 1'b0;
        case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                is_imm  = (opcode == OPC_OP_IMM);
                use_rs1 = 1'b1;
                use_rs2 = (opcode == OPC_OP);
                if (opcode == OPC_OP) begin
                    // Only funct7 0000000, or 0100000 for SUB/SRA, is a legal RV32I OP.
                    dec_legal = (funct7 == 7'b0000000) ||
                                ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                end else begin
                    dec_legal = 1'b1;
                end
                case (funct3)
                    3'b000: dec_op = (!is_imm && funct7[5]) ? OPV_SUB : OPV_ADD;
                    3'b001: begin
                        dec_op   = OPV_SLL;
                        is_shift = 1'b1;
                    end
                    3'b010: begin
                        dec_op  = OPV_SLT;
                        dec_sun = 1'b1;
                    end
                    3'b011: dec_op = OPV_SLTU;
                    3'b100: dec_op = OPV_XOR;
                    3'b101: begin
                        // instr[30] is funct7[5] for OP and imm[10] for OP-IMM.
                        is_shift = 1'b1;
                        if (instr[30]) begin
                            dec_op  = OPV_SRA;
                            dec_sun = 1'b1;
                        end else begin
                            dec_op = OPV_SRL;
                        end
                    end
                    3'b110: dec_op = OPV_OR;
                    default: dec_op = OPV_AND;
                endcase
            end
            OPC_LUI: begin
                is_lui    = 1'b1;
                dec_legal = 1'b1;
                dec_op    = OPV_ADD;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Hazard detection and forwarding (x0 never forwards and reads 0)
    // ------------------------------------------------------------------
    logic            ex_hit_a, ex_hit_b;
    logic            wb_hit_a, wb_hit_b;
    logic [XLEN-1:0] fwd_a, fwd_b;
    logic            stall;

    assign ex_hit_a = (rs1_addr != '0) && issue_valid_q && rd_we_q && (rd_addr_q == rs1_addr);
    assign ex_hit_b = (rs2_addr != '0) && issue_valid_q && rd_we_q && (rd_addr_q == rs2_addr);
    assign wb_hit_a = (rs1_addr != '0) && wb_we_q && (wb_rd_q == rs1_addr);
    assign wb_hit_b = (rs2_addr != '0) && wb_we_q && (wb_rd_q == rs2_addr);

`ifdef ALU_ISSUE_WB_FWD_EN
    logic unused_use_flags;
    assign unused_use_flags = use_rs1 ^ use_rs2;

    assign fwd_a = (rs1_addr == '0) ? '0 :
                   ex_hit_a ? alu_result_comb :
                   wb_hit_a ? alu_result_wb : rs1_data;
    assign fwd_b = (rs2_addr == '0) ? '0 :
                   ex_hit_b ? alu_result_comb :
                   wb_hit_b ? alu_result_wb : rs2_data;
    assign stall = 1'b0;
`else
    logic unused_wb_result;
    assign unused_wb_result = ^alu_result_wb;

    assign fwd_a = (rs1_addr == '0) ? '0 : ex_hit_a ? alu_result_comb : rs1_data;
    assign fwd_b = (rs2_addr == '0) ? '0 : ex_hit_b ? alu_result_comb : rs2_data;
    // A WB-only hazard waits one cycle so the register file read returns the written value.
    // Only operands the instruction actually reads can stall it; a flushed or illegal
    // instruction never stalls.
    assign stall = instr_valid && !flush && dec_legal &&
                   ((use_rs1 && wb_hit_a && !ex_hit_a) || (use_rs2 && wb_hit_b && !ex_hit_b));
`endif

    assign instr_ready = !halt && !stall;

    // ------------------------------------------------------------------
    // Operand selection
    // ------------------------------------------------------------------
    logic [XLEN-1:0] dec_a, dec_b;

    always_comb begin
        dec_a = fwd_a;
        dec_b = fwd_b;
        if (is_lui) begin
            dec_a = '0;
            dec_b = XLEN'({instr[31:12], 12'b0});
        end else if (is_imm) begin
            dec_b = is_shift ? XLEN'(instr[24:20]) : XLEN'($signed(instr[31:20]));
        end else if (is_shift) begin
            dec_b = XLEN'(fwd_b[4:0]);
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    logic accept;
    logic issue;

    assign accept = instr_valid && !flush && !stall;
    assign issue  = accept && dec_legal;

    always_comb begin
        op_val_d      = OPV_NOP;
        sun_d         = 1'b0;
        op_a_d        = '0;
        op_b_d        = '0;
        rd_addr_d     = '0;
        rd_we_d       = 1'b0;
        issue_valid_d = 1'b0;
        if (issue) begin
            op_val_d      = dec_op;
            sun_d         = dec_sun;
            op_a_d        = dec_a;
            op_b_d        = dec_b;
            rd_addr_d     = instr[11:7];
            rd_we_d       = 1'b1;
            issue_valid_d = 1'b1;
        end
        illegal_d = accept && !dec_legal;
        wb_rd_d   = rd_addr_q;
        wb_we_d   = rd_we_q && issue_valid_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_val_q      <= OPV_NOP;
            sun_q         <= 1'b0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            rd_addr_q     <= '0;
            rd_we_q       <= 1'b0;
            issue_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
            wb_rd_q       <= '0;
            wb_we_q       <= 1'b0;
        end else if (!halt) begin
            op_val_q      <= op_val_d;
            sun_q         <= sun_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            rd_addr_q     <= rd_addr_d;
            rd_we_q       <= rd_we_d;
            issue_valid_q <= issue_valid_d;
            illegal_q     <= illegal_d;
            wb_rd_q       <= wb_rd_d;
            wb_we_q       <= wb_we_d;
        end
    end

    assign op_val            = op_val_q;
    assign signed_unsigned_n = sun_q;
    assign operand_a         = op_a_q;
    assign operand_b         = op_b_q;
    assign rd_addr           = rd_addr_q;
    assign rd_we             = rd_we_q;
    assign issue_valid       = issue_valid_q;
    assign illegal_instr     = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed vectors for alu_issue_stage decode, plus hand sequences for
// reset, EX/WB forwarding, x0 guard, halt/flush and the illegal-instruction pulse.
// Expected WB-hazard behaviour follows the ALU_ISSUE_WB_FWD_EN build option.

module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic        flush;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] alu_result_comb;
    logic [31:0] alu_result_wb;
    logic [3:0]  op_val;
    logic        signed_unsigned_n;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        issue_valid;
    logic        illegal_instr;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk               (clk),
        .rst               (rst),
        .halt              (halt),
        .flush             (flush),
        .instr_valid       (instr_valid),
        .instr             (instr),
        .instr_ready       (instr_ready),
        .rs1_addr          (rs1_addr),
        .rs2_addr          (rs2_addr),
        .rs1_data          (rs1_data),
        .rs2_data          (rs2_data),
        .alu_result_comb   (alu_result_comb),
        .alu_result_wb     (alu_result_wb),
        .op_val            (op_val),
        .signed_unsigned_n (signed_unsigned_n),
        .operand_a         (operand_a),
        .operand_b         (operand_b),
        .rd_addr           (rd_addr),
        .rd_we             (rd_we),
        .issue_valid       (issue_valid),
        .illegal_instr     (illegal_instr)
    );

    // {op, sun, a, b, rd, we, issue_valid, illegal}
    logic [76:0] act;
    assign act = {op_val, signed_unsigned_n, operand_a, operand_b, rd_addr, rd_we, issue_valid, illegal_instr};

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] A = 32'h8000_0010;
    localparam logic [31:0] B = 32'h0000_0123;

    function automatic logic [76:0] ex(input logic [3:0] op, input logic sun, input logic [31:0] a,
                                       input logic [31:0] b, input logic [4:0] rd, input logic we,
                                       input logic iv, input logic ill);
        return {op, sun, a, b, rd, we, iv, ill};
    endfunction

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    task automatic chk(input string nm, input logic [127:0] actual, input logic [127:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h", nm, actual, expected);
        end
    endtask

    task automatic drv(input logic v, input logic [31:0] ins, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] cmb, input logic [31:0] wbv,
                       input logic fl, input logic hl);
        instr_valid     = v;
        instr           = ins;
        rs1_data        = d1;
        rs2_data        = d2;
        alu_result_comb = cmb;
        alu_result_wb   = wbv;
        flush           = fl;
        halt            = hl;
    endtask

    task automatic idle();
        drv(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [76:0] exp;
    } vec_t;

    vec_t vecs[21];

    initial begin
        // ---------------- stimulus table ----------------
        vecs[0]  = '{i_type(12'hFFB, 5'd0, 3'b000, 5'd1), A, B, ex(4'b0001, 0, 32'h0, 32'hFFFF_FFFB, 5'd1, 1, 1, 0)};
        vecs[1]  = '{r_type(7'h00, 5'd7, 5'd6, 3'b000, 5'd5), A, B, ex(4'b0001, 0, A, B, 5'd5, 1, 1, 0)};
        vecs[2]  = '{r_type(7'h20, 5'd7, 5'd6, 3'b000, 5'd5), A, B, ex(4'b0010, 0, A, B, 5'd5, 1, 1, 0)};
        vecs[3]  = '{r_type(7'h00, 5'd7, 5'd6, 3'b010, 5'd8), A, B, ex(4'b0011, 1, A, B, 5'd8, 1, 1, 0)};
        vecs[4]  = '{r_type(7'h00, 5'd7, 5'd6, 3'b011, 5'd8), A, B, ex(4'b1011, 0, A, B, 5'd8, 1, 1, 0)};
        vecs[5]  = '{r_type(7'h00, 5'd7, 5'd6, 3'b100, 5'd8), A, B, ex(4'b0110, 0, A, B, 5'd8, 1, 1, 0)};
        vecs[6]  = '{r_type(7'h00, 5'd7, 5'd6, 3'b110, 5'd8), A, B, ex(4'b0101, 0, A, B, 5'd8, 1, 1, 0)};
        vecs[7]  = '{r_type(7'h00, 5'd7, 5'd6, 3'b111, 5'd8), A, B, ex(4'b0100, 0, A, B, 5'd8, 1, 1, 0)};
        vecs[8]  = '{r_type(7'h00, 5'd7, 5'd6, 3'b001, 5'd8), A, B, ex(4'b0111, 0, A, 32'h3, 5'd8, 1, 1, 0)};
        vecs[9]  = '{r_type(7'h00, 5'd7, 5'd6, 3'b101, 5'd8), A, B, ex(4'b1000, 0, A, 32'h3, 5'd8, 1, 1, 0)};
        vecs[10] = '{r_type(7'h20, 5'd7, 5'd6, 3'b101, 5'd8), A, B, ex(4'b1001, 1, A, 32'h3, 5'd8, 1, 1, 0)};
        vecs[11] = '{i_type(12'h407, 5'd6, 3'b101, 5'd9), A, B, ex(4'b1001, 1, A, 32'h7, 5'd9, 1, 1, 0)};
        vecs[12] = '{i_type(12'h005, 5'd6, 3'b101, 5'd9), A, B, ex(4'b1000, 0, A, 32'h5, 5'd9, 1, 1, 0)};
        vecs[13] = '{i_type(12'hFFF, 5'd6, 3'b010, 5'd9), A, B, ex(4'b0011, 1, A, 32'hFFFF_FFFF, 5'd9, 1, 1, 0)};
        vecs[14] = '{i_type(12'h800, 5'd6, 3'b011, 5'd9), A, B, ex(4'b1011, 0, A, 32'hFFFF_F800, 5'd9, 1, 1, 0)};
        vecs[15] = '{i_type(12'h0F0, 5'd6, 3'b111, 5'd9), A, B, ex(4'b0100, 0, A, 32'h0000_00F0, 5'd9, 1, 1, 0)};
        vecs[16] = '{{20'hABCDE, 5'd10, 7'b0110111}, A, B, ex(4'b0001, 0, 32'h0, 32'hABCD_E000, 5'd10, 1, 1, 0)};
        vecs[17] = '{32'h0000_0073, A, B, ex(4'b0000, 0, 32'h0, 32'h0, 5'd0, 0, 0, 1)};
        vecs[18] = '{r_type(7'h01, 5'd7, 5'd6, 3'b000, 5'd5), A, B, ex(4'b0000, 0, 32'h0, 32'h0, 5'd0, 0, 0, 1)};
        vecs[19] = '{r_type(7'h20, 5'd7, 5'd6, 3'b111, 5'd5), A, B, ex(4'b0000, 0, 32'h0, 32'h0, 5'd0, 0, 0, 1)};
        vecs[20] = '{r_type(7'h00, 5'd7, 5'd6, 3'b000, 5'd0), A, B, ex(4'b0001, 0, A, B, 5'd0, 1, 1, 0)};

        // ---------------- reset ----------------
        rst = 1'b1;
        idle();
        #2;
        chk("reset_state", act, 77'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("idle_after_reset", act, 77'h0);

        // ---------------- table-driven decode ----------------
        for (int i = 0; i < 21; i++) begin
            logic [31:0] ins;
            ins = vecs[i].ins;
            drv(1'b1, ins, vecs[i].d1, vecs[i].d2, 32'hC0C0_C0C0, 32'hB0B0_B0B0, 1'b0, 1'b0);
            #1;
            chk($sformatf("vec%0d_comb", i), {instr_ready, rs1_addr, rs2_addr}, {1'b1, ins[19:15], ins[24:20]});
            tick();
            chk($sformatf("vec%0d_issue", i), act, vecs[i].exp);
            idle();
            tick();
            tick();
        end

        // ---------------- illegal pulse lasts one cycle ----------------
        drv(1'b1, 32'h0000_0073, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        chk("ecall_pulse", act, ex(4'b0000, 0, 32'h0, 32'h0, 5'd0, 0, 0, 1));
        idle();
        tick();
        chk("ecall_pulse_end", act, 77'h0);
        tick();

        // ---------------- EX forwarding ----------------
        drv(1'b1, i_type(12'd7, 5'd0, 3'b000, 5'd1), 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        chk("ex_producer", act, ex(4'b0001, 0, 32'h0, 32'h7, 5'd1, 1, 1, 0));
        drv(1'b1, r_type(7'h00, 5'd1, 5'd1, 3'b000, 5'd2), 32'h0, 32'h0, 32'h7, 32'hDEAD_BEEF, 1'b0, 1'b0);
        #1;
        chk("ex_fwd_ready", instr_ready, 1'b1);
        tick();
        chk("ex_fwd_issue", act, ex(4'b0001, 0, 32'h7, 32'h7, 5'd2, 1, 1, 0));
        idle();
        tick();
        tick();

        // ---------------- WB forwarding / stall ----------------
        drv(1'b1, i_type(12'd1, 5'd0, 3'b000, 5'd3), 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        drv(1'b1, i_type(12'd2, 5'd0, 3'b000, 5'd11), 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        chk("wb_indep_issue", act, ex(4'b0001, 0, 32'h0, 32'h2, 5'd11, 1, 1, 0));
        drv(1'b1, r_type(7'h20, 5'd0, 5'd3, 3'b000, 5'd4), 32'h55, 32'h66, 32'h99, 32'h10, 1'b0, 1'b0);
        #1;
`ifdef ALU_ISSUE_WB_FWD_EN
        chk("wb_fwd_ready", instr_ready, 1'b1);
        tick();
        chk("wb_fwd_issue", act, ex(4'b0010, 0, 32'h10, 32'h0, 5'd4, 1, 1, 0));
`else
        chk("wb_stall_ready", instr_ready, 1'b0);
        tick();
        chk("wb_stall_bubble", act, 77'h0);
        chk("wb_stall_release", instr_ready, 1'b1);
        tick();
        chk("wb_stall_issue", act, ex(4'b0010, 0, 32'h55, 32'h0, 5'd4, 1, 1, 0));
`endif
        idle();
        tick();
        tick();

        // ---------------- x0 never forwards ----------------
        drv(1'b1, r_type(7'h00, 5'd7, 5'd6, 3'b000, 5'd0), A, B, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        drv(1'b1, r_type(7'h00, 5'd0, 5'd0, 3'b000, 5'd2), 32'h33, 32'h44, 32'h77, 32'h88, 1'b0, 1'b0);
        #1;
        chk("x0_ready", instr_ready, 1'b1);
        tick();
        chk("x0_guard_issue", act, ex(4'b0001, 0, 32'h0, 32'h0, 5'd2, 1, 1, 0));
        idle();
        tick();
        tick();

        // ---------------- halt / halt+flush / flush ----------------
        drv(1'b1, r_type(7'h00, 5'd7, 5'd6, 3'b000, 5'd5), A, B, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        chk("halt_pre", act, ex(4'b0001, 0, A, B, 5'd5, 1, 1, 0));
        for (int c = 0; c < 3; c++) begin
            drv(1'b1, r_type(7'h20, 5'd7, 5'd6, 3'b000, 5'd5), A, B, 32'h0, 32'h0, (c == 1), 1'b1);
            #1;
            chk($sformatf("halt_ready%0d", c), instr_ready, 1'b0);
            tick();
            chk($sformatf("halt_frozen%0d", c), act, ex(4'b0001, 0, A, B, 5'd5, 1, 1, 0));
        end
        drv(1'b1, r_type(7'h20, 5'd7, 5'd6, 3'b000, 5'd5), A, B, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("halt_release_ready", instr_ready, 1'b1);
        tick();
        chk("halt_resume_issue", act, ex(4'b0010, 0, A, B, 5'd5, 1, 1, 0));
        drv(1'b1, r_type(7'h00, 5'd7, 5'd6, 3'b010, 5'd8), A, B, 32'h0, 32'h0, 1'b1, 1'b0);
        #1;
        chk("flush_ready", instr_ready, 1'b1);
        tick();
        chk("flush_bubble", act, 77'h0);
        idle();
        tick();

        // ---------------- async reset mid-stream ----------------
        drv(1'b1, r_type(7'h00, 5'd7, 5'd6, 3'b000, 5'd5), A, B, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        chk("pre_reset_issue", act, ex(4'b0001, 0, A, B, 5'd5, 1, 1, 0));
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_clear", act, 77'h0);
        idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("post_reset_idle", act, 77'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
